// File: rtl/sync_frame_deserializer_pkg.sv
// Shared types and default parameters for the sync-framed serial deserializer.
package sync_frame_deserializer_pkg;

    // Default bits per word, sync pattern and data words per frame.
    localparam int unsigned DefWidth    = 8;
    localparam logic [7:0]  DefSyncWord = 8'hA5;
    localparam int unsigned DefFrameLen = 4;

    // HUNT searches the bit stream for the sync word; DATA assembles frame words.
    typedef enum logic {
        StHunt = 1'b0,
        StData = 1'b1
    } state_e;

endpackage

// File: rtl/sync_frame_deserializer_sync_shift.sv
// History shift register with a sync-pattern comparator on the post-shift value.
module sync_shift
    import sync_frame_deserializer_pkg::*;
#(
    parameter int unsigned      WIDTH     = DefWidth,
    parameter logic [WIDTH-1:0] SYNC_WORD = DefSyncWord
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_en,
    input  logic in_bit,
    output logic match
);

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_shifted;

    // New bit enters at the LSB; older bits move toward the MSB.
    assign hist_shifted = (hist_q << 1) | WIDTH'(in_bit);

    // Match is judged on the value the register is about to take.
    assign match = shift_en && (hist_shifted == SYNC_WORD);

    // History register: clear takes priority so a new hunt starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_shifted;
        end
    end

endmodule

// File: rtl/sync_frame_deserializer.sv
// Serial-to-parallel deserializer: hunts for a sync word, then assembles a fixed
// number of MSB-first data words and presents them on a valid/ready output register.
module sync_frame_deserializer
    import sync_frame_deserializer_pkg::*;
#(
    parameter int unsigned      WIDTH     = DefWidth,
    parameter logic [WIDTH-1:0] SYNC_WORD = DefSyncWord,
    parameter int unsigned      FRAME_LEN = DefFrameLen
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_start,
    output logic             locked,
    output logic             overflow
);

    localparam int unsigned       BitCntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit  = BitCntW'(WIDTH - 1);
    localparam logic [7:0]         LastWord = 8'(FRAME_LEN - 1);

    state_e             state_q, state_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]         word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0]   asm_q, asm_d;
    logic [WIDTH-1:0]   asm_shifted;

    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               overflow_q, overflow_d;

    logic hunt_shift;
    logic data_shift;
    logic sync_match;
    logic word_done;
    logic frame_done;
    logic accept;

    assign hunt_shift  = in_valid && (state_q == StHunt);
    assign data_shift  = in_valid && (state_q == StData);
    assign word_done   = data_shift && (bit_cnt_q == LastBit);
    assign frame_done  = word_done && (word_cnt_q == LastWord);
    assign accept      = out_valid_q && out_ready;
    assign asm_shifted = (asm_q << 1) | WIDTH'(in_bit);

    // History path; cleared at frame end so trailing bits are hunted afresh.
    sync_shift #(
        .WIDTH    (WIDTH),
        .SYNC_WORD(SYNC_WORD)
    ) u_sync_shift (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_done),
        .shift_en(hunt_shift),
        .in_bit  (in_bit),
        .match   (sync_match)
    );

    // Next state: lock on a sync match, unlock after the last word of the frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHunt: begin
                if (sync_match) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (frame_done) begin
                    state_d = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit/word counters and word assembly; a dropped word still advances the word count.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        if (sync_match) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end
        if (data_shift) begin
            asm_d = asm_shifted;
            if (word_done) begin
                bit_cnt_d  = '0;
                word_cnt_d = frame_done ? 8'd0 : word_cnt_q + 8'd1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Counter and assembly registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
        end
    end

    // Output register: load when empty or being drained, otherwise drop and flag overflow.
    always_comb begin
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        frame_start_d = frame_start_q;
        overflow_d    = 1'b0;
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d    = asm_shifted;
                out_valid_d   = 1'b1;
                frame_start_d = (word_cnt_q == 8'd0);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign overflow    = overflow_q;
    assign locked      = (state_q == StData);

endmodule

// File: tb/tb_sync_frame_deserializer.sv
// Self-checking bench for sync_frame_deserializer: table-driven frames, directed
// corner cases, and random streams compared against a behavioural model.
module tb_sync_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_bit;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_start;
    logic       locked;
    logic       overflow;

    always #5 clk = ~clk;

    sync_frame_deserializer #(
        .WIDTH    (8),
        .SYNC_WORD(8'hA5),
        .FRAME_LEN(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_start(frame_start),
        .locked     (locked),
        .overflow   (overflow)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int ovf_cnt  = 0;

    logic [7:0] got_d[$];
    logic       got_fs[$];

    // Behavioural model: stream-level view (hunting flag, history value, word progress,
    // one-deep output slot).
    bit m_locked;
    int m_hist;
    int m_word;
    int m_nbits;
    int m_wcount;
    bit m_ov;
    bit m_ovf;
    bit m_fs;
    int m_od;

    typedef struct {
        logic [15:0] lead;
        logic [31:0] data;
        int          exp_n;
        logic [31:0] exp_words;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_hist   = 0;
        m_word   = 0;
        m_nbits  = 0;
        m_wcount = 0;
        m_ov     = 0;
        m_ovf    = 0;
        m_fs     = 0;
        m_od     = 0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic r);
        bit done;
        bit first;
        int word;
        done  = 0;
        first = 0;
        word  = 0;
        m_ovf = 0;
        if (v) begin
            if (!m_locked) begin
                m_hist = (m_hist * 2 + int'(b)) % 256;
                if (m_hist == 165) begin
                    m_locked = 1;
                    m_nbits  = 0;
                    m_wcount = 0;
                end
            end else begin
                m_word = (m_word * 2 + int'(b)) % 256;
                m_nbits++;
                if (m_nbits == 8) begin
                    done    = 1;
                    m_nbits = 0;
                    word    = m_word;
                    first   = (m_wcount == 0);
                    m_wcount++;
                    if (m_wcount == 4) begin
                        m_locked = 0;
                        m_wcount = 0;
                        m_hist   = 0;
                    end
                end
            end
        end
        if (done) begin
            if (!m_ov || r) begin
                m_od = word;
                m_fs = first;
                m_ov = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_ov && r) begin
            m_ov = 0;
        end
    endtask

    // One clock: drive at negedge, record handshakes, then compare just after posedge.
    task automatic step(input logic b, input logic v, input logic r);
        @(negedge clk);
        in_bit    = b;
        in_valid  = v;
        out_ready = r;
        if (out_valid && r) begin
            got_d.push_back(out_data);
            got_fs.push_back(frame_start);
        end
        @(posedge clk);
        #1;
        model_step(b, v, r);
        if (overflow) ovf_cnt++;
        check("locked", locked, m_locked);
        check("out_valid", out_valid, m_ov);
        check("overflow", overflow, m_ovf);
        if (m_ov) begin
            check("out_data", out_data, m_od);
            check("frame_start", frame_start, m_fs);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic r);
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, r);
            step(b[i], 1'b1, r);
        end
    endtask

    task automatic clear_log();
        got_d.delete();
        got_fs.delete();
        ovf_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_log();
    endtask

    task automatic check_words(input string name, input logic [63:0] exp, input int n);
        check({name, "_count"}, got_d.size(), n);
        for (int j = 0; j < n; j++) begin
            if (j < got_d.size()) begin
                check({name, "_word"}, got_d[j], exp[(n - 1 - j) * 8 +: 8]);
                check({name, "_fs"}, got_fs[j], (j % 4) == 0);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_out_data"}, out_data, 0);
        check({name, "_frame_start"}, frame_start, 0);
        check({name, "_locked"}, locked, 0);
        check({name, "_overflow"}, overflow, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h00A5, 32'h12345678, 4, 32'h12345678};
        tbl[1] = '{16'hA45A, 32'h00000000, 0, 32'h00000000};
        tbl[2] = '{16'h3CA5, 32'hA5A5A5A5, 4, 32'hA5A5A5A5};
        tbl[3] = '{16'hFFA5, 32'hDEADBEEF, 4, 32'hDEADBEEF};

        rst       = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table: lead pattern then four data words, in_valid every 2nd cycle, ready high.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            for (int k = 1; k >= 0; k--) send_byte(tbl[i].lead[k * 8 +: 8], 1, 1'b1);
            for (int k = 3; k >= 0; k--) send_byte(tbl[i].data[k * 8 +: 8], 1, 1'b1);
            for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);
            check("tbl_count", got_d.size(), tbl[i].exp_n);
            for (int j = 0; j < tbl[i].exp_n; j++) begin
                if (j < got_d.size()) begin
                    check("tbl_word", got_d[j], tbl[i].exp_words[(3 - j) * 8 +: 8]);
                    check("tbl_fs", got_fs[j], j == 0);
                end
            end
            check("tbl_locked_end", locked, 0);
        end

        // Back-to-back frames with no gap.
        do_reset();
        send_byte(8'hA5, 0, 1'b1);
        for (int k = 3; k >= 0; k--) send_byte(8'h12 + 8'(k * 16), 0, 1'b1);
        send_byte(8'hA5, 0, 1'b1);
        for (int k = 3; k >= 0; k--) send_byte(8'h9A + 8'(k), 0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        check_words("b2b", 64'h42322212_9D9C9B9A, 8);

        // Backpressure across two completions: first held, second dropped.
        do_reset();
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        check("bp_held_data", out_data, 8'h12);
        check("bp_held_valid", out_valid, 1);
        check("bp_ovf_pulses", ovf_cnt, 1);
        send_byte(8'h56, 0, 1'b1);
        check("bp_locked_mid", locked, 1);
        send_byte(8'h78, 0, 1'b1);
        check("bp_locked_end", locked, 0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        check("bp_count", got_d.size(), 3);
        if (got_d.size() == 3) begin
            check("bp_w0", got_d[0], 8'h12);
            check("bp_w1", got_d[1], 8'h56);
            check("bp_w2", got_d[2], 8'h78);
        end

        // Acceptance on the completion cycle: new word replaces the old one, no overflow.
        do_reset();
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h12, 0, 1'b1);
        for (int i = 7; i >= 1; i--) step(1'b0 ^ ((8'h34 >> i) & 8'h1) != 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("sim_data", out_data, 8'h34);
        check("sim_valid", out_valid, 1);
        send_byte(8'h56, 0, 1'b1);
        send_byte(8'h78, 0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        check("sim_ovf_pulses", ovf_cnt, 0);
        check_words("sim", 64'h12345678, 4);

        // Asynchronous reset after two words and three bits, then a clean frame.
        do_reset();
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h12, 0, 1'b1);
        send_byte(8'h34, 0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        model_reset();
        clear_log();
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hA5, 0, 1'b1);
        for (int k = 3; k >= 0; k--) send_byte(8'hC1 + 8'(k * 3), 0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        check_words("postrst", 64'hCAC7C4C1, 4);

        // Random stream, sync-biased, with random gaps and backpressure.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                if ($urandom_range(0, 2) == 0) step(1'($urandom), 1'b0, $urandom_range(0, 3) != 0);
                step(b[i], 1'b1, $urandom_range(0, 3) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
